instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/cpu_pkg.sv | 14 +
 rtl/instr_fetch_branch_target_adder.sv | 10 +
 rtl/instr_fetch.sv | 137 +++++++++++++
 tb/tb_instr_fetch.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: FSM state encoding and the default reset PC / fetch stride.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_PC_STEP  = 32'd4;

endpackage

// File: rtl/instr_fetch_branch_target_adder.sv
// Branch target = base + (word offset << 2); 32-bit wrap-around, carry discarded.
module Branch_Target_Adder (
    input  logic [31:0] base,
    input  logic [31:0] offset,
    output logic [31:0] target
);

    assign target = base + {offset[29:0], 2'b00};

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding memory request, single-entry output hold register.
// Optional perf counters (fetch_cnt_o, stall_cnt_o) are built when INSTR_FETCH_PERF_CNT_EN is defined.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic         clk_i,
    input  logic         rst_i,
    output logic         imem_req_o,
    output logic [31:0]  imem_addr_o,
    input  logic         imem_valid_i,
    input  logic [31:0]  imem_data_i,
    input  logic         redirect_i,
    input  logic [31:0]  redirect_base_i,
    input  logic [31:0]  br_offset_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [31:0]  instr_o,
    output logic [31:0]  pc_o,
    output logic [31:0]  pc_plus4_o,
    output logic [15:0]  imm_o,
`ifdef INSTR_FETCH_PERF_CNT_EN
    output logic [31:0]  fetch_cnt_o,
    output logic [31:0]  stall_cnt_o,
`endif
    output fetch_state_e state_o
);

    // valid_o/ready_i: a word transfers on every cycle both are high; while valid_o is high
    // and no transfer or redirect occurs, instr_o and pc_o are held unchanged.

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  held_pc_q, held_pc_d;
    logic         valid_q, valid_d;
    logic [31:0]  target;
    logic [31:0]  seq_pc;

    Branch_Target_Adder u_target (
        .base   (redirect_base_i),
        .offset (br_offset_i),
        .target (target)
    );

    assign seq_pc = pc_q + PC_STEP;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            held_pc_q <= RESET_PC;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            held_pc_q <= held_pc_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        held_pc_d   = held_pc_q;
        valid_d     = valid_q;
        imem_req_o  = 1'b0;
        imem_addr_o = pc_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                imem_req_o = 1'b1;
                if (redirect_i) begin
                    // A response arriving with the redirect is simply dropped; otherwise
                    // the in-flight word must be swallowed in DROP first.
                    pc_d    = target;
                    state_d = imem_valid_i ? REQ : DROP;
                end else if (imem_valid_i) begin
                    instr_d   = imem_data_i;
                    held_pc_d = pc_q;
                    valid_d   = 1'b1;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (redirect_i) begin
                    valid_d = 1'b0;
                    pc_d    = target;
                    state_d = REQ;
                end else if (ready_i) begin
                    // Issue the sequential request in the same cycle as the transfer.
                    imem_req_o  = 1'b1;
                    imem_addr_o = seq_pc;
                    pc_d        = seq_pc;
                    valid_d     = 1'b0;
                    state_d     = REQ;
                end
            end
            DROP: begin
                if (redirect_i) pc_d = target;
                if (imem_valid_i) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    assign valid_o    = valid_q;
    assign instr_o    = instr_q;
    assign pc_o       = held_pc_q;
    assign pc_plus4_o = held_pc_q + PC_STEP;
    assign imm_o      = instr_q[15:0];
    assign state_o    = state_q;

`ifdef INSTR_FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (valid_q && ready_i)  fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (valid_q && !ready_i) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: variable-latency memory model, request-address and transfer scoreboards.
module tb_instr_fetch;
    import cpu_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         imem_req_o;
    logic [31:0]  imem_addr_o;
    logic         imem_valid_i;
    logic [31:0]  imem_data_i;
    logic         redirect_i;
    logic [31:0]  redirect_base_i;
    logic [31:0]  br_offset_i;
    logic         valid_o;
    logic         ready_i;
    logic [31:0]  instr_o;
    logic [31:0]  pc_o;
    logic [31:0]  pc_plus4_o;
    logic [15:0]  imm_o;
    fetch_state_e state_o;
`ifdef INSTR_FETCH_PERF_CNT_EN
    logic [31:0]  fetch_cnt_o;
    logic [31:0]  stall_cnt_o;
`endif

    instr_fetch dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_valid_i    (imem_valid_i),
        .imem_data_i     (imem_data_i),
        .redirect_i      (redirect_i),
        .redirect_base_i (redirect_base_i),
        .br_offset_i     (br_offset_i),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .instr_o         (instr_o),
        .pc_o            (pc_o),
        .pc_plus4_o      (pc_plus4_o),
        .imm_o           (imm_o),
`ifdef INSTR_FETCH_PERF_CNT_EN
        .fetch_cnt_o     (fetch_cnt_o),
        .stall_cnt_o     (stall_cnt_o),
`endif
        .state_o         (state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a + 32'h2001_0005;
    endfunction

    // ---------------- memory model ----------------
    int          mem_lat = 1;
    int          mem_cnt;
    logic        mem_busy;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        stale_valid;

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_busy  <= 1'b0;
            mem_valid <= 1'b0;
            mem_cnt   <= 0;
            mem_addr  <= '0;
            mem_data  <= '0;
        end else if (mem_busy) begin
            if (mem_valid) begin
                mem_valid <= 1'b0;
                mem_busy  <= 1'b0;
            end else begin
                if (mem_cnt == 1) begin
                    mem_valid <= 1'b1;
                    mem_data  <= word_at(mem_addr);
                end
                mem_cnt <= mem_cnt - 1;
            end
        end else if (imem_req_o) begin
            mem_busy <= 1'b1;
            mem_addr <= imem_addr_o;
            mem_cnt  <= mem_lat - 1;
            if (mem_lat == 1) begin
                mem_valid <= 1'b1;
                mem_data  <= word_at(imem_addr_o);
            end
        end
    end

    assign imem_valid_i = mem_valid | stale_valid;
    assign imem_data_i  = stale_valid ? 32'hDEAD_BEEF : mem_data;

    // ---------------- scoreboards ----------------
    logic [31:0] addr_q[$];
    logic [63:0] exp_q[$];
    int          xfer_cnt = 0;
    int          last_xfer_cyc = 0;
    bit          gap_check = 1'b0;

    always @(negedge clk_i) begin
        logic [63:0] e;
        if (rst_i && imem_req_o && !mem_busy) begin
            if (addr_q.size() == 0) check("req_unexpected", 32'(addr_q.size()), 32'd1);
            else check("req_addr", imem_addr_o, addr_q.pop_front());
        end
        if (rst_i && valid_o && ready_i) begin
            xfer_cnt++;
            if (gap_check && xfer_cnt > 1) check("xfer_gap", 32'(cyc - last_xfer_cyc), 32'd2);
            last_xfer_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("xfer_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("xfer_pc", pc_o, e[63:32]);
                check("xfer_instr", instr_o, e[31:0]);
                check("xfer_pc_plus4", pc_plus4_o, e[63:32] + 32'd4);
                check("xfer_imm", 32'(imm_o), 32'(e[15:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!valid_o && n < 50) begin
            tick();
            n++;
        end
        check(tag, 32'(valid_o), 32'd1);
    endtask

    // Caller guarantees the DUT is holding a word; it transfers this cycle.
    task automatic accept_one(input logic [31:0] pc);
        exp_q.push_back({pc, word_at(pc)});
        addr_q.push_back(pc + 32'd4);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] base, input logic [31:0] off);
        redirect_i      = 1'b1;
        redirect_base_i = base;
        br_offset_i     = off;
        tick();
        redirect_i      = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        ready_i         = 1'b0;
        redirect_i      = 1'b0;
        redirect_base_i = '0;
        br_offset_i     = '0;
        stale_valid     = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_pc", pc_o, 32'h0000_0000);
        check("rst_pc_plus4", pc_plus4_o, 32'd4);
        check("rst_state", 32'(state_o), 32'(IDLE));

        // Sequential stream, latency 1, decode always ready.
        for (int i = 0; i < 5; i++) addr_q.push_back(32'(i * 4));
        for (int i = 0; i < 4; i++) exp_q.push_back({32'(i * 4), word_at(32'(i * 4))});
        gap_check = 1'b1;
        ready_i   = 1'b1;
        rst_i     = 1'b1;
        check("idle_no_req", 32'(imem_req_o), 32'd0);
        tick();
        check("first_req", 32'(imem_req_o), 32'd1);
        for (int i = 0; i < 40 && xfer_cnt < 4; i++) tick();
        ready_i   = 1'b0;
        gap_check = 1'b0;
        check("seq_xfers", 32'(xfer_cnt), 32'd4);

        // Back-pressure: held word stays put for 5 stalled cycles.
        addr_q.push_back(32'h0);
        do_reset();
        wait_valid("stall_valid");
        for (int i = 0; i < 5; i++) begin
            check("stall_instr", instr_o, 32'h2001_0005);
            check("stall_pc", pc_o, 32'h0);
            tick();
        end
`ifdef INSTR_FETCH_PERF_CNT_EN
        check("stall_cnt", stall_cnt_o, 32'd5);
        check("fetch_cnt0", fetch_cnt_o, 32'd0);
`endif
        accept_one(32'h0);
`ifdef INSTR_FETCH_PERF_CNT_EN
        check("fetch_cnt1", fetch_cnt_o, 32'd1);
        check("stall_cnt_after", stall_cnt_o, 32'd5);
`endif

        // Redirect while holding: 0x10 + (-2 << 2) = 0x8.
        wait_valid("hold4_valid");
        addr_q.push_back(32'h8);
        redirect(32'h0000_0010, 32'hFFFF_FFFE);
        check("redir_hold_valid", 32'(valid_o), 32'd0);
        check("redir_hold_req", 32'(imem_req_o), 32'd1);
        check("redir_hold_addr", imem_addr_o, 32'h0000_0008);
        wait_valid("tgt8_valid");
        accept_one(32'h8);

        // Redirect coincident with a transfer: transfer completes, target wins.
        wait_valid("hold12_valid");
        exp_q.push_back({32'hC, word_at(32'hC)});
        addr_q.push_back(32'h104);
        ready_i = 1'b1;
        redirect(32'h0000_0100, 32'h0000_0001);
        ready_i = 1'b0;
        check("redir_xfer_addr", imem_addr_o, 32'h104);

        // Redirect in REQ with latency 3: in-flight word must be discarded.
        wait_valid("hold104_valid");
        mem_lat = 3;
        accept_one(32'h104);
        addr_q.push_back(32'h200);
        redirect(32'h0000_0200, 32'h0);
        check("drop_state", 32'(state_o), 32'(DROP));
        wait_valid("drop_tgt_valid");
        check("drop_pc", pc_o, 32'h200);
        check("drop_instr", instr_o, word_at(32'h200));
        accept_one(32'h200);

        // Redirect in the same cycle the response arrives.
        n = 0;
        while (!imem_valid_i && n < 20) begin
            tick();
            n++;
        end
        check("coinc_resp_seen", 32'(imem_valid_i), 32'd1);
        addr_q.push_back(32'h300);
        redirect(32'h0000_0300, 32'h0);
        check("coinc_state", 32'(state_o), 32'(REQ));
        check("coinc_valid", 32'(valid_o), 32'd0);
        wait_valid("coinc_tgt_valid");
        check("coinc_pc", pc_o, 32'h300);
        mem_lat = 1;
        accept_one(32'h300);

        // PC wrap from 0xFFFF_FFFC to 0.
        wait_valid("hold304_valid");
        addr_q.push_back(32'hFFFF_FFFC);
        redirect(32'hFFFF_FFFC, 32'h0);
        wait_valid("wrap_valid");
        accept_one(32'hFFFF_FFFC);
        check("wrap_addr", imem_addr_o, 32'h0);

        // Reset mid-request with stale responses during and right after reset.
        wait_valid("hold0_valid");
        mem_lat = 3;
        accept_one(32'h0);
        tick();
        rst_i = 1'b0;
        #1;
        check("midrst_valid", 32'(valid_o), 32'd0);
        check("midrst_req", 32'(imem_req_o), 32'd0);
        check("midrst_state", 32'(state_o), 32'(IDLE));
        stale_valid = 1'b1;
        tick();
        stale_valid = 1'b0;
        tick();
        addr_q.push_back(32'h0);
        rst_i       = 1'b1;
        stale_valid = 1'b1;
        tick();
        stale_valid = 1'b0;
        check("postrst_valid", 32'(valid_o), 32'd0);
        check("postrst_state", 32'(state_o), 32'(REQ));
        check("postrst_addr", imem_addr_o, 32'h0);
        wait_valid("postrst_word_valid");
        check("postrst_pc", pc_o, 32'h0);
        accept_one(32'h0);
        tick();
        tick();

        check("sb_exp_empty", 32'(exp_q.size()), 32'd0);
        check("sb_addr_empty", 32'(addr_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
